// File: rtl/rca_fault_detector.sv
`default_nettype none
// ============================================================================
//  Module      : rca_fault_detector
//  Description : Online self-test engine for the fault-tolerant 4-bit
//                ripple-carry adder. When start is pulsed, it drives a fixed
//                8-entry vector table through the adder under test PASSES
//                times. It compares the observed slice sums and carry-outs
//                against expected values one cycle later. The results feed
//                sticky per-slice fault flags (sf/cf), and these flags drive
//                the spare-selection generator.
//  Ports       : clk        - system clock, rising edge
//                clr        - synchronous active-high reset, aborts any run
//                start      - one-cycle test request, ignored while busy
//                sum_obs    - observed slice sums from the adder under test
//                carry_obs  - observed slice carry-outs (bit i = slice i)
//                test_a/b   - registered test operands
//                test_cin   - registered test carry-in
//                lut_o      - registered index of the vector being driven
//                busy       - test in progress
//                done       - one-cycle completion pulse
//                sf / cf    - sticky per-slice sum / carry fault flags
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_fault_detector #(
    parameter int WIDTH  = 4,   // fixed vector table only covers 4 slices
    parameter int PASSES = 2    // 1..15; a slice must fail every pass
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] sum_obs,
    input  logic [WIDTH-1:0] carry_obs,
    output logic [WIDTH-1:0] test_a,
    output logic [WIDTH-1:0] test_b,
    output logic             test_cin,
    output logic [2:0]       lut_o,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sf,
    output logic [WIDTH-1:0] cf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] c_last_pass = 4'(PASSES - 1);
    localparam logic [2:0] c_last_idx  = 3'd7;

    // Stimulus for table entry idx, packed as {a, b, cin}.
    function automatic logic [2*WIDTH:0] f_operands(input logic [2:0] idx);
        logic [2*WIDTH:0] v;
        case (idx)
            3'd0:    v = {4'b0000, 4'b0000, 1'b0};
            3'd1:    v = {4'b1111, 4'b0000, 1'b0};
            3'd2:    v = {4'b1111, 4'b0000, 1'b1};
            3'd3:    v = {4'b0101, 4'b1010, 1'b0};
            3'd4:    v = {4'b0101, 4'b1010, 1'b1};
            3'd5:    v = {4'b1010, 4'b0101, 1'b0};
            3'd6:    v = {4'b1111, 4'b1111, 1'b0};
            default: v = {4'b0000, 4'b0000, 1'b1};
        endcase
        return v;
    endfunction

    // Fault-free response for table entry idx, packed as {sum, carries}.
    function automatic logic [2*WIDTH-1:0] f_expect(input logic [2:0] idx);
        logic [2*WIDTH-1:0] v;
        case (idx)
            3'd0:    v = {4'b0000, 4'b0000};
            3'd1:    v = {4'b1111, 4'b0000};
            3'd2:    v = {4'b0000, 4'b1111};
            3'd3:    v = {4'b1111, 4'b0000};
            3'd4:    v = {4'b0000, 4'b1111};
            3'd5:    v = {4'b1111, 4'b0000};
            3'd6:    v = {4'b1110, 4'b1111};
            default: v = {4'b0001, 4'b0000};
        endcase
        return v;
    endfunction

    logic [1:0]       r_state;
    logic [2:0]       r_idx;
    logic [2:0]       r_prev_idx;   // vector whose response arrives this cycle
    logic             r_prev_vld;   // a vector is in flight through the adder
    logic [3:0]       r_pass;
    logic [WIDTH-1:0] r_hit_s;
    logic [WIDTH-1:0] r_hit_c;
    logic [WIDTH-1:0] r_acc_s;
    logic [WIDTH-1:0] r_acc_c;
    logic [WIDTH-1:0] r_test_a;
    logic [WIDTH-1:0] r_test_b;
    logic             r_test_cin;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sf;
    logic [WIDTH-1:0] r_cf;

    logic [2*WIDTH-1:0] w_exp;
    logic [WIDTH-1:0]   w_miss_s;
    logic [WIDTH-1:0]   w_miss_c;
    logic [WIDTH-1:0]   w_hit_s_end;
    logic [WIDTH-1:0]   w_hit_c_end;
    logic [WIDTH-1:0]   w_acc_s_new;
    logic [WIDTH-1:0]   w_acc_c_new;
    logic [2:0]         w_next_idx;
    logic [2*WIDTH:0]   w_next_ops;
    logic [2*WIDTH:0]   w_first_ops;

    always_comb begin
        w_exp       = f_expect(r_prev_idx);
        w_miss_s    = r_prev_vld ? (sum_obs   ^ w_exp[2*WIDTH-1:WIDTH]) : '0;
        w_miss_c    = r_prev_vld ? (carry_obs ^ w_exp[WIDTH-1:0])       : '0;
        w_hit_s_end = r_hit_s | w_miss_s;
        w_hit_c_end = r_hit_c | w_miss_c;
        // Transient filter: a slice survives only if it failed in every pass.
        w_acc_s_new = (r_pass == 4'd0) ? w_hit_s_end : (r_acc_s & w_hit_s_end);
        w_acc_c_new = (r_pass == 4'd0) ? w_hit_c_end : (r_acc_c & w_hit_c_end);
        w_next_idx  = r_idx + 3'd1;
        w_next_ops  = f_operands(w_next_idx);
        w_first_ops = f_operands(3'd0);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_prev_idx <= 3'd0;
            r_prev_vld <= 1'b0;
            r_pass     <= 4'd0;
            r_hit_s    <= '0;
            r_hit_c    <= '0;
            r_acc_s    <= '0;
            r_acc_c    <= '0;
            r_test_a   <= '0;
            r_test_b   <= '0;
            r_test_cin <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sf       <= '0;
            r_cf       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_idx      <= 3'd0;
                        {r_test_a, r_test_b, r_test_cin} <= w_first_ops;
                        r_busy     <= 1'b1;
                        r_pass     <= 4'd0;
                        r_hit_s    <= '0;
                        r_hit_c    <= '0;
                        r_prev_vld <= 1'b0;
                    end
                end

                S_RUN: begin
                    r_hit_s    <= w_hit_s_end;
                    r_hit_c    <= w_hit_c_end;
                    r_prev_idx <= r_idx;
                    r_prev_vld <= 1'b1;
                    if (r_idx == c_last_idx) begin
                        // Last vector is still in flight; FLUSH collects it.
                        r_state    <= S_FLUSH;
                        r_idx      <= 3'd0;
                        r_test_a   <= '0;
                        r_test_b   <= '0;
                        r_test_cin <= 1'b0;
                    end else begin
                        r_idx <= w_next_idx;
                        {r_test_a, r_test_b, r_test_cin} <= w_next_ops;
                    end
                end

                S_FLUSH: begin
                    r_acc_s    <= w_acc_s_new;
                    r_acc_c    <= w_acc_c_new;
                    r_prev_vld <= 1'b0;
                    if (r_pass < c_last_pass) begin
                        r_pass   <= r_pass + 4'd1;
                        r_hit_s  <= '0;
                        r_hit_c  <= '0;
                        r_state  <= S_RUN;
                        r_idx    <= 3'd0;
                        {r_test_a, r_test_b, r_test_cin} <= w_first_ops;
                    end else begin
                        r_hit_s  <= w_hit_s_end;
                        r_hit_c  <= w_hit_c_end;
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        // Flags are sticky across tests; only clr clears them.
                        r_sf     <= r_sf | w_acc_s_new;
                        r_cf     <= r_cf | w_acc_c_new;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign test_a   = r_test_a;
    assign test_b   = r_test_b;
    assign test_cin = r_test_cin;
    assign lut_o    = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sf       = r_sf;
    assign cf       = r_cf;

endmodule
`default_nettype wire

// File: tb/tb_rca_fault_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca_fault_detector
//  Description : Directed self-checking bench for rca_fault_detector. A
//                1-cycle behavioural adder answers the test vectors. Stuck-at
//                and transient faults can be injected into its outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_fault_detector;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [3:0] sum_obs;
    logic [3:0] carry_obs;
    logic [3:0] test_a;
    logic [3:0] test_b;
    logic       test_cin;
    logic [2:0] lut_o;
    logic       busy;
    logic       done;
    logic [3:0] sf;
    logic [3:0] cf;

    int total = 0;
    int bad   = 0;

    // Fault injection controls
    logic [3:0] sa0_s    = 4'b0000;
    logic [3:0] sa1_s    = 4'b0000;
    logic       trans_c1 = 1'b0;

    // Expected stimulus table (hand-entered)
    logic [3:0] ea [8] = '{4'h0, 4'hF, 4'hF, 4'h5, 4'h5, 4'hA, 4'hF, 4'h0};
    logic [3:0] eb [8] = '{4'h0, 4'h0, 4'h0, 4'hA, 4'hA, 4'h5, 4'hF, 4'h0};
    logic       ec [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rca_fault_detector #(.WIDTH(4), .PASSES(2)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .sum_obs   (sum_obs),
        .carry_obs (carry_obs),
        .test_a    (test_a),
        .test_b    (test_b),
        .test_cin  (test_cin),
        .lut_o     (lut_o),
        .busy      (busy),
        .done      (done),
        .sf        (sf),
        .cf        (cf)
    );

    always #5 clk = ~clk;

    // Behavioural adder under test: ripple-carry, one register stage.
    logic [3:0] mdl_ideal_s;
    logic [3:0] mdl_ideal_c;
    logic [3:0] mdl_s;
    logic [3:0] mdl_c;
    logic       mdl_cy;
    logic [3:0] v2_seen;

    always_comb begin
        mdl_ideal_s = 4'b0000;
        mdl_ideal_c = 4'b0000;
        mdl_cy      = test_cin;
        for (int i = 0; i < 4; i++) begin
            mdl_ideal_s[i] = test_a[i] ^ test_b[i] ^ mdl_cy;
            mdl_cy         = (test_a[i] & test_b[i]) | (mdl_cy & (test_a[i] ^ test_b[i]));
            mdl_ideal_c[i] = mdl_cy;
        end
        mdl_s = (mdl_ideal_s & ~sa0_s) | sa1_s;
        mdl_c = mdl_ideal_c;
        if (trans_c1 && busy && lut_o == 3'd2 && v2_seen == 4'd0)
            mdl_c[1] = ~mdl_c[1];
    end

    always_ff @(posedge clk) begin
        sum_obs   <= mdl_s;
        carry_obs <= mdl_c;
        if (clr || (start && !busy && !done))
            v2_seen <= 4'd0;
        else if (busy && lut_o == 3'd2)
            v2_seen <= v2_seen + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then check every cycle 1..20 after the start edge.
    // extra_start: cycle in which start is re-asserted (should be ignored).
    task automatic run_test(input string tag, input int extra_start,
                            input logic [3:0] exp_sf, input logic [3:0] exp_cf);
        int         k;
        logic       in_run;
        logic [2:0] el;
        logic [8:0] evec;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            in_run = (c >= 1 && c <= 8) || (c >= 10 && c <= 17);
            k      = (c <= 8) ? c - 1 : c - 10;
            el     = in_run ? 3'(k) : 3'd0;
            evec   = in_run ? {ea[el], eb[el], ec[el]} : 9'd0;
            chk($sformatf("%s c%0d lut", tag, c), 32'(lut_o), 32'(el));
            chk($sformatf("%s c%0d vec", tag, c), 32'({test_a, test_b, test_cin}), 32'(evec));
            chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(c <= 18));
            chk($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == 19));
            if (c >= 19) begin
                chk($sformatf("%s c%0d sf", tag, c), 32'(sf), 32'(exp_sf));
                chk($sformatf("%s c%0d cf", tag, c), 32'(cf), 32'(exp_cf));
            end
            start = (c == extra_start);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        chk("reset outputs",
            32'({test_a, test_b, test_cin, lut_o, busy, done, sf, cf}), 32'd0);
        @(negedge clk);

        // Fault-free sweep
        run_test("clean", 0, 4'b0000, 4'b0000);
        // start during RUN (cycle 5) and in the DONE cycle are both ignored
        run_test("busy_start", 5, 4'b0000, 4'b0000);
        run_test("done_start", 19, 4'b0000, 4'b0000);

        // Sum bit 2 stuck-at-0: exposed by vectors 1,3,5,6 in both passes
        sa0_s = 4'b0100;
        run_test("sa0_s2", 0, 4'b0100, 4'b0000);

        // Stickiness: clean adder does not clear the flag
        sa0_s = 4'b0000;
        run_test("sticky", 0, 4'b0100, 4'b0000);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr outputs",
            32'({test_a, test_b, test_cin, lut_o, busy, done, sf, cf}), 32'd0);
        @(negedge clk);

        // Transient carry fault on slice 1, only in pass 0 vector 2
        trans_c1 = 1'b1;
        run_test("transient", 0, 4'b0000, 4'b0000);
        trans_c1 = 1'b0;

        // Abort: clr during cycle 7 of a run with sum bit 0 stuck-at-1
        sa1_s = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("abort c%0d lut", c), 32'(lut_o), 32'(c - 1));
            if (c < 7) @(negedge clk);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort lut", 32'(lut_o), 32'd0);
        chk("abort sf", 32'(sf), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("abort idle c%0d done", c), 32'(done), 32'd0);
        end

        // Rerun with the stuck-at-1 still present: vectors 0,2,4,6 expose it
        run_test("abort_rerun", 0, 4'b0001, 4'b0000);
        sa1_s = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
